// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, dark levels,
// default refresh prescaler width and the frame record held in pending/active.
package seg7_pkg;

  localparam int DEFAULT_DIV_WIDTH = 17;

  localparam logic [6:0] SEG_DARK  = 7'b1111111;
  localparam logic [3:0] CTRL_DARK = 4'b1111;

  // Active-low glyphs, bit order g..a; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } frame_t;

  localparam frame_t FRAME_RESET = '{value: 16'h0000, dp: 4'h0, blank: 4'hF};

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = GLYPH_TABLE[digit_i];

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Four-digit multiplexed seven-segment driver with double-buffered display data;
// new data only reaches the display at frame boundaries so a frame never tears.
module seven_segment_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [6:0]  Port,
  output logic        Dp,
  output logic [3:0]  control,
  output logic        frame_done
);

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [1:0]           digit_q, digit_d;
  frame_t               pend_q, pend_d;
  frame_t               act_q, act_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [3:0]           ctrl_q, ctrl_d;

  logic                 wrap;
  logic                 boundary;
  logic [3:0]           act_digits [4];
  logic [3:0]           cur_digit;
  logic [6:0]           cur_glyph;

  assign wrap       = &presc_q;
  assign boundary   = wrap && (digit_q == 2'd3);
  assign frame_done = boundary;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign act_digits[gi] = act_q.value[4*gi +: 4];
    end
  endgenerate

  assign cur_digit = act_digits[digit_q];

  hex_to_seg7 u_glyph (
    .digit_i (cur_digit),
    .seg_n_o (cur_glyph)
  );

  always_comb begin
    presc_d      = presc_q + DIV_WIDTH'(1);
    digit_d      = wrap ? digit_q + 2'd1 : digit_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    act_d        = act_q;
    seg_d        = SEG_DARK;
    ctrl_d       = CTRL_DARK;
    dp_d         = 1'b1;

    // Transfer sees the old pending contents; a coincident load refills pending.
    if (boundary && pend_valid_q) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_d.value = value;
      pend_d.dp    = dp_in;
      pend_d.blank = blank;
      pend_valid_d = 1'b1;
    end

    if (!act_q.blank[digit_q]) begin
      seg_d  = cur_glyph;
      ctrl_d = ~(4'b0001 << digit_q);
      dp_d   = ~act_q.dp[digit_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      digit_q      <= 2'd0;
      pend_q       <= FRAME_RESET;
      pend_valid_q <= 1'b0;
      act_q        <= FRAME_RESET;
      seg_q        <= SEG_DARK;
      ctrl_q       <= CTRL_DARK;
      dp_q         <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      act_q        <= act_d;
      seg_q        <= seg_d;
      ctrl_q       <= ctrl_d;
      dp_q         <= dp_d;
    end
  end

  assign Port    = seg_q;
  assign Dp      = dp_q;
  assign control = ctrl_q;

endmodule
